// File: rtl/camsim_pkg.sv
// Shared types and constants for the camsim_tx synthetic camera-bus source.
// The LFSR constants are only referenced when CAMSIM_NOISE_EN is defined.
package camsim_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VBLANK   = 2'd1,
    LINE_ACT = 2'd2,
    LINE_BLK = 2'd3
  } state_t;

  localparam logic [1:0] PAT_HRAMP = 2'd0;
  localparam logic [1:0] PAT_VRAMP = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_MIX   = 2'd3;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/camsim_pattern.sv
// Test-pattern generator: maps pixel/line position to a 12-bit value.
// With CAMSIM_NOISE_EN defined, pattern 3 becomes LFSR noise instead of a sum ramp.
module camsim_pattern
  import camsim_pkg::*;
(
`ifdef CAMSIM_NOISE_EN
  input  logic        clk,
  input  logic        rst,
  input  logic        seed,
  input  logic        adv,
`endif
  input  logic [11:0] px,
  input  logic [11:0] ly,
  input  logic [1:0]  pat,
  input  logic [11:0] fcnt,
  output logic [11:0] pixel
);

`ifdef CAMSIM_NOISE_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (seed) begin
      lfsr_d = LFSR_SEED;
    end else if (adv) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`endif

  always_comb begin
    pixel = 12'h000;
    case (pat)
      PAT_HRAMP: pixel = px;
      PAT_VRAMP: pixel = ly;
      PAT_CHECK: pixel = (px[3] ^ ly[3]) ? 12'hFFF : 12'h000;
`ifdef CAMSIM_NOISE_EN
      PAT_MIX:   pixel = lfsr_q[11:0];
`else
      PAT_MIX:   pixel = px + ly + fcnt;
`endif
      default:   pixel = 12'h000;
    endcase
  end

endmodule

// File: rtl/camsim_tx.sv
// Synthetic camera-bus transmitter: cam_clk divider, frame-timing FSM and counters.
// Optional build macro CAMSIM_NOISE_EN swaps pattern 3 for LFSR noise.
module camsim_tx
  import camsim_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 320,
  parameter int H_BLANK  = 32,
  parameter int V_ACTIVE = 256,
  parameter int V_BLANK  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern,
  output logic        cam_clk,
  output logic [11:0] cam_pixel,
  output logic        cam_hsync,
  output logic        cam_vsync,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  if (H_BLANK < 1) begin : g_hblank_chk
    $error("camsim_tx: H_BLANK must be at least 1");
  end
  if (CLK_DIV < 1) begin : g_div_chk
    $error("camsim_tx: CLK_DIV must be at least 1");
  end

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] H_LAST   = 16'(H_ACTIVE + H_BLANK - 1);
  localparam logic [15:0] V_LAST   = 16'(V_BLANK + V_ACTIVE - 1);
  localparam logic [15:0] H_ACT_W  = 16'(H_ACTIVE);
  localparam logic [15:0] V_BLK_W  = 16'(V_BLANK);
  localparam state_t      START_ST = (V_BLANK == 0) ? LINE_ACT : VBLANK;

  logic [15:0] div_q, div_d;
  logic        cam_clk_q, cam_clk_d;
  state_t      state_q, state_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic [1:0]  pat_q, pat_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic        fdone_q, fdone_d;

  logic        div_term, tick, x_wrap, last_px, frame_start;
  logic [15:0] x_nxt, y_nxt;

  always_comb begin
    div_term    = (div_q == DIV_LAST);
    tick        = div_term & cam_clk_q;
    x_wrap      = (x_q == H_LAST);
    x_nxt       = x_wrap ? 16'd0 : x_q + 16'd1;
    y_nxt       = x_wrap ? y_q + 16'd1 : y_q;
    last_px     = x_wrap & (y_q == V_LAST);

    div_d       = div_term ? 16'd0 : div_q + 16'd1;
    cam_clk_d   = cam_clk_q ^ div_term;
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    pat_d       = pat_q;
    fcnt_d      = fcnt_q;
    fdone_d     = 1'b0;
    frame_start = 1'b0;

    // State and counters describe the pixel period driven after this tick
    if (tick) begin
      case (state_q)
        IDLE: frame_start = enable;
        default: begin
          if (last_px) begin
            fdone_d = 1'b1;
            fcnt_d  = fcnt_q + 16'd1;
            if (enable) begin
              frame_start = 1'b1;
            end else begin
              state_d = IDLE;
              x_d     = 16'd0;
              y_d     = 16'd0;
            end
          end else begin
            x_d = x_nxt;
            y_d = y_nxt;
            if (y_nxt < V_BLK_W)       state_d = VBLANK;
            else if (x_nxt < H_ACT_W)  state_d = LINE_ACT;
            else                       state_d = LINE_BLK;
          end
        end
      endcase
    end

    if (frame_start) begin
      state_d = START_ST;
      x_d     = 16'd0;
      y_d     = 16'd0;
      pat_d   = pattern;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= 16'd0;
      cam_clk_q <= 1'b0;
      state_q   <= IDLE;
      x_q       <= 16'd0;
      y_q       <= 16'd0;
      pat_q     <= 2'd0;
      fcnt_q    <= 16'd0;
      fdone_q   <= 1'b0;
    end else begin
      div_q     <= div_d;
      cam_clk_q <= cam_clk_d;
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      pat_q     <= pat_d;
      fcnt_q    <= fcnt_d;
      fdone_q   <= fdone_d;
    end
  end

  logic        line_act;
  logic [11:0] ly;
  logic [11:0] pat_pixel;

  assign line_act = (state_q == LINE_ACT);
  assign ly       = y_q[11:0] - V_BLK_W[11:0];

  camsim_pattern u_pattern (
`ifdef CAMSIM_NOISE_EN
    .clk   (clk),
    .rst   (rst),
    .seed  (tick & frame_start),
    .adv   (tick & line_act),
`endif
    .px    (x_q[11:0]),
    .ly    (ly),
    .pat   (pat_q),
    .fcnt  (fcnt_q[11:0]),
    .pixel (pat_pixel)
  );

  // Outputs decode registered state only, so they move solely on pixel ticks
  assign cam_clk     = cam_clk_q;
  assign cam_hsync   = line_act;
  assign cam_vsync   = line_act | (state_q == LINE_BLK);
  assign cam_pixel   = line_act ? pat_pixel : 12'h000;
  assign busy        = (state_q != IDLE);
  assign frame_done  = fdone_q;
  assign frame_count = fcnt_q;

endmodule

// File: doc/camsim_tx.md
Name: camsim_tx

Overview:
- Synthetic camera-bus transmitter that drives cam_clk, cam_pixel, cam_hsync and cam_vsync.
- Its timing contract is exactly the one cambus receives, so it is the source end of that bus.
- Used for bring-up and loopback: its outputs connect to the camerica camera-bus inputs in place of the real camera.
- Generates programmable frame timing and test patterns from the 50MHz main clock; controlled by a few register-level signals.

Parameters:
- CLK_DIV, 2: clk cycles per cam_clk half-period; cam_clk = clk/(2*CLK_DIV); must be >=1.
- H_ACTIVE, 320: active pixels per line.
- H_BLANK, 32: blank pixel periods per line.
- V_ACTIVE, 256: active lines per frame.
- V_BLANK, 8: blank lines per frame, emitted before the active lines.

Ports:
- clk  in  1  50MHz main clock.
- rst  in  1  reset; asynchronous, active-high.
- enable  in  1  level; start frames / stop after the current frame.
- pattern  in  2  pattern select, sampled at frame start.
- cam_clk  out  1  generated pixel clock.
- cam_pixel  out  12  pixel data.
- cam_hsync  out  1  high while line-active pixels are driven.
- cam_vsync  out  1  high for the whole active-line region of a frame.
- busy  out  1  high while a frame is in progress (not IDLE).
- frame_done  out  1  one-clk pulse at end of each frame.
- frame_count  out  16  completed frames, wraps 16'hFFFF->0.

Behaviour:
- Reset values: all outputs 0 and state IDLE; the cam_clk phase divider is cleared.
- cam_clk divider:
  - Counts 0..CLK_DIV-1 and toggles cam_clk on terminal count.
  - Free-runs whenever rst is low, including in IDLE.
- Output update timing:
  - cam_pixel, cam_hsync and cam_vsync change only on the clk edge where cam_clk goes 1->0.
  - The receiver therefore samples stable data on cam_clk rising.
  - Each such edge is one "pixel tick".
- Counters x (pixel within line, 0..H_ACTIVE+H_BLANK-1) and y (line within frame, 0..V_BLANK+V_ACTIVE-1) advance on pixel ticks only.
- FSM states: IDLE, VBLANK, LINE_ACT, LINE_BLK.
  - IDLE:
    - Syncs low, pixel 0.
    - On a pixel tick with enable=1: latch pattern into pat_q, x=y=0, go to VBLANK.
    - busy goes high on that same clk edge.
  - VBLANK:
    - Syncs low, pixel 0, lasts V_BLANK full lines.
    - Go to LINE_ACT when y reaches V_BLANK at x=0.
    - If V_BLANK=0, go directly to LINE_ACT.
  - LINE_ACT:
    - vsync=1, hsync=1, cam_pixel=pattern(px, ly), where px=x and ly=y-V_BLANK.
    - After H_ACTIVE ticks, go to LINE_BLK.
  - LINE_BLK:
    - vsync=1, hsync=0, cam_pixel=0, lasts H_BLANK ticks.
    - If the line was not the last active line: go to LINE_ACT.
    - If it was the last line: pulse frame_done, increment frame_count, drop vsync on the same tick.
    - Then go to VBLANK (new frame, pat_q re-latched) if enable=1, else go to IDLE.
- Blank-interval rules:
  - H_BLANK=0 is illegal; the syncs' low phase is required by the receiver. Enforced by an elaboration assertion.
  - V_BLANK=0 is allowed.
- Patterns (12-bit results, truncate on overflow):
  - 0: px[11:0]
  - 1: ly[11:0]
  - 2: (px[3]^ly[3]) ? 12'hFFF : 12'h000
  - 3: px+ly+frame_count[11:0]
- enable deasserted mid-frame: the current frame completes normally, then IDLE. Partial frames never occur.
- pattern changes mid-frame are ignored until the next frame start.
- rst mid-frame: immediate return to reset values; outputs are 0 asynchronously.

Optional Feature:
- Macro: CAMSIM_NOISE_EN.
- When defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 on reset and each frame start) advances every pixel tick in LINE_ACT.
  - Pattern 3 outputs lfsr[11:0] instead of the sum.
- When undefined: no LFSR logic; pattern 3 is the px+ly+frame_count sum.

Decomposition:
- Package camsim_pkg:
  - state enum (IDLE, VBLANK, LINE_ACT, LINE_BLK);
  - pattern codes PAT_HRAMP=0, PAT_VRAMP=1, PAT_CHECK=2, PAT_MIX=3;
  - LFSR seed and tap constants.
- One sub-module, camsim_pattern: combinational px/ly/pat_q/frame_count to 12-bit pixel, plus the optional LFSR register.
- FSM, divider and counters stay in camsim_tx.

Test Plan:
- Timing: CLK_DIV=2, H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_BLANK=1, enable=1, pattern=0.
  - cam_clk period 4 clks.
  - Per frame: 6 blank ticks, then 3x(hsync high 4 ticks with pixels 0,1,2,3; hsync low 2 ticks) with vsync high 18 ticks.
  - frame_done once every 24 ticks; frame_count 1,2,3.
- Setup margin: cam_pixel/syncs sampled on cam_clk rising equal the values set at the preceding falling edge; no change occurs within 1 clk of a rising edge.
- Enable/pattern control:
  - Drop enable in the middle of line 1: frame finishes, busy falls after frame_done, syncs stay low thereafter.
  - Change pattern 0->2 mid-frame: the new pattern appears only from the next frame.
- Pattern values:
  - Pattern 2 with H_ACTIVE=16, V_ACTIVE=16: pixel at (px=8, ly=0) is 12'hFFF, at (8,8) is 12'h000.
  - Pattern 3 without CAMSIM_NOISE_EN at frame_count=5, px=2, ly=1: 12'h008.
- Reset mid-frame: assert rst in the middle of LINE_ACT; all outputs 0 with no clk edge. After release with enable=1, the first frame begins with VBLANK and frame_count=0.
- Receiver loopback: connect to cambus with CLK_DIV=2; vid_locked asserts and the line capture contents match pattern 1 (each line value = ly).
